// File: rtl/sweep_stimulus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sweep_stimulus_sequencer_if
// Description : Signal bundle between the sweep sequencer and its environment.
//               The sequencer uses the master view. The slave view belongs to
//               the side that owns the benchmark DUT and the record sink.
//   start        seq <- env   begin a sweep (honoured only when idle)
//   abort        seq <- env   terminate the current sweep
//   stim         seq -> env   vector driven onto the benchmark DUT inputs
//   resp_in      seq <- env   benchmark DUT response
//   rec_valid    seq -> env   record available
//   rec_ready    seq <- env   record sink accepts
//   rec_vector   seq -> env   vector of the current record
//   rec_response seq -> env   captured response of the current record
//   busy         seq -> env   sweep in progress
//   done         seq -> env   one-cycle pulse after the final record handshake
//   rec_count    seq -> env   records accepted in the current/last sweep
// Revision    : 1.0 - initial release
// ============================================================================
interface sweep_stimulus_sequencer_if #(
  parameter int N_WIDTH = 7,
  parameter int R_WIDTH = 1
);
  logic               start;
  logic               abort;
  logic [N_WIDTH-1:0] stim;
  logic [R_WIDTH-1:0] resp_in;
  logic               rec_valid;
  logic               rec_ready;
  logic [N_WIDTH-1:0] rec_vector;
  logic [R_WIDTH-1:0] rec_response;
  logic               busy;
  logic               done;
  logic [N_WIDTH:0]   rec_count;

  modport master (
    input  start, abort, resp_in, rec_ready,
    output stim, rec_valid, rec_vector, rec_response, busy, done, rec_count
  );

  modport slave (
    output start, abort, resp_in, rec_ready,
    input  stim, rec_valid, rec_vector, rec_response, busy, done, rec_count
  );
endinterface
`default_nettype wire

// File: rtl/sweep_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sweep_stimulus_sequencer
// Description : Exhaustive stimulus sequencer. Drives vectors 0..2^N_WIDTH-1
//               onto a benchmark DUT, holds each one SETTLE_CYCLES cycles,
//               captures the response and emits (vector, response) records
//               on a valid/ready stream.
//   CK     : clock, all logic on the rising edge
//   reset  : synchronous active-high reset
//   bus    : master view of sweep_stimulus_sequencer_if (control, stimulus,
//            response and record stream; see the interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_stimulus_sequencer #(
  parameter int N_WIDTH       = 7,
  parameter int R_WIDTH       = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       CK,
  input  logic                       reset,
  sweep_stimulus_sequencer_if.master bus
);

  // Settle counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_WIDTH:0] C_COUNT_ONE = {{N_WIDTH{1'b0}}, 1'b1};
  localparam logic [N_WIDTH-1:0] C_STIM_ONE = {{(N_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [N_WIDTH-1:0] stim_q,      stim_d;
  logic [CNT_W-1:0]   settle_q,    settle_d;
  logic [N_WIDTH-1:0] vector_q,    vector_d;
  logic [R_WIDTH-1:0] response_q,  response_d;
  logic [N_WIDTH:0]   count_q,     count_d;
  logic               done_q,      done_d;

  // Final vector detected by all-ones compare, so stim never wraps in a sweep.
  logic w_last;
  assign w_last = &stim_q;

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stim_q     <= '0;
      settle_q   <= '0;
      vector_q   <= '0;
      response_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      settle_q   <= settle_d;
      vector_q   <= vector_d;
      response_q <= response_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    settle_d   = settle_q;
    vector_d   = vector_q;
    response_d = response_q;
    count_d    = count_q;
    done_d     = 1'b0;

    // abort outranks start and any handshake in the same cycle; the record
    // in flight is dropped and not counted.
    if (bus.abort) begin
      state_d = S_IDLE;
      stim_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d  = S_SETTLE;
            stim_d   = '0;
            count_d  = '0;
            settle_d = C_RELOAD;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            response_d = bus.resp_in;
            vector_d   = stim_q;
            state_d    = S_EMIT;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.rec_ready) begin
            count_d = count_q + C_COUNT_ONE;
            if (w_last) begin
              state_d = S_IDLE;
              stim_d  = '0;
              done_d  = 1'b1;
            end else begin
              stim_d   = stim_q + C_STIM_ONE;
              settle_d = C_RELOAD;
              state_d  = S_SETTLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          stim_d  = '0;
        end
      endcase
    end
  end

  // All outputs come straight from registers, so rec_ready has no
  // combinational path to rec_valid or stim.
  assign bus.stim         = stim_q;
  assign bus.rec_valid    = (state_q == S_EMIT);
  assign bus.rec_vector   = vector_q;
  assign bus.rec_response = response_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;
  assign bus.rec_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sweep_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_stimulus_sequencer
// Description : Bench for sweep_stimulus_sequencer. Instance A (N=7, S=2)
//               sees parity responses; instance B (N=4, S=1) sees a response
//               that lags stim by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_stimulus_sequencer;

  localparam int N  = 7;
  localparam int R  = 1;
  localparam int S  = 2;
  localparam int NV = 1 << N;
  localparam int NB  = 4;
  localparam int RB  = 8;
  localparam int SB  = 1;
  localparam int NVB = 1 << NB;

  logic CK = 1'b0;
  logic reset = 1'b1;
  always #5 CK = ~CK;

  sweep_stimulus_sequencer_if #(.N_WIDTH(N),  .R_WIDTH(R))  bus_a ();
  sweep_stimulus_sequencer_if #(.N_WIDTH(NB), .R_WIDTH(RB)) bus_b ();

  sweep_stimulus_sequencer #(.N_WIDTH(N), .R_WIDTH(R), .SETTLE_CYCLES(S)) dut_a (
    .CK(CK), .reset(reset), .bus(bus_a.master));
  sweep_stimulus_sequencer #(.N_WIDTH(NB), .R_WIDTH(RB), .SETTLE_CYCLES(SB)) dut_b (
    .CK(CK), .reset(reset), .bus(bus_b.master));

  function automatic logic [R-1:0] fa(input int x);
    logic [N-1:0] v;
    v = N'(x);
    return ^v;
  endfunction

  function automatic logic [RB-1:0] fb(input int x);
    return RB'(x * 29 + 7);
  endfunction

  // Benchmark DUTs: A is instantaneous parity, B responds one cycle late.
  assign bus_a.resp_in = fa(int'(bus_a.stim));
  logic [RB-1:0] resp_b_q = '0;
  always @(posedge CK) resp_b_q <= fb(int'(bus_b.stim));
  assign bus_b.resp_in = resp_b_q;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not reached within cycle budget at time %0t", name, $time);
  endtask

  // ---------------- reference model for A (updated at the active edge) ----
  typedef struct packed { logic [N-1:0] v; logic [R-1:0] r; } rec_a_t;
  typedef struct packed { logic [NB-1:0] v; logic [RB-1:0] r; } rec_b_t;
  rec_a_t q_a[$];
  rec_b_t q_b[$];

  bit m_busy = 0, m_done = 0;
  int m_stim = 0, m_held = 0, m_cnt = 0;

  always @(posedge CK) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_stim = 0; m_held = 0; m_cnt = 0;
      q_a.delete();
    end else if (bus_a.abort) begin
      m_busy = 0; m_done = 0; m_stim = 0;
      q_a.delete();
    end else if (!m_busy) begin
      m_done = 0;
      if (bus_a.start) begin
        m_busy = 1; m_stim = 0; m_held = 1; m_cnt = 0;
        q_a.delete();
        for (int v = 0; v < NV; v++) q_a.push_back('{v: N'(v), r: fa(v)});
      end
    end else begin
      m_done = 0;
      if (m_held > S && bus_a.rec_ready) begin
        m_cnt++;
        if (m_stim == NV - 1) begin
          m_busy = 0; m_done = 1; m_stim = 0;
        end else begin
          m_stim++; m_held = 1;
        end
      end else begin
        m_held++;
      end
    end
  end

  // ---------------- monitor for A (opposite edge) -------------------------
  bit           prev_stall = 0;
  logic [N-1:0] prev_vec;
  logic [R-1:0] prev_resp;

  always @(negedge CK) begin
    rec_a_t e;
    if (chk_en) begin
      chk("a_busy", 32'(bus_a.busy), 32'(m_busy));
      chk("a_rec_valid", 32'(bus_a.rec_valid), 32'(m_busy && m_held > S));
      chk("a_stim", 32'(bus_a.stim), 32'(m_stim));
      chk("a_done", 32'(bus_a.done), 32'(m_done));
      chk("a_rec_count", 32'(bus_a.rec_count), 32'(m_cnt));
      if (prev_stall) begin
        chk("a_hold_vector", 32'(bus_a.rec_vector), 32'(prev_vec));
        chk("a_hold_response", 32'(bus_a.rec_response), 32'(prev_resp));
      end
      if (bus_a.rec_valid && bus_a.rec_ready && !bus_a.abort && !reset) begin
        if (q_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_record_unexpected: got vector 0x%0h expected none", bus_a.rec_vector);
        end else begin
          e = q_a.pop_front();
          chk("a_record_vector", 32'(bus_a.rec_vector), 32'(e.v));
          chk("a_record_response", 32'(bus_a.rec_response), 32'(e.r));
        end
      end
    end
    prev_stall = bus_a.rec_valid && !bus_a.rec_ready && !bus_a.abort && !reset;
    prev_vec   = bus_a.rec_vector;
    prev_resp  = bus_a.rec_response;
  end

  // ---------------- monitor for B -----------------------------------------
  always @(negedge CK) begin
    rec_b_t e;
    if (chk_en && bus_b.rec_valid && bus_b.rec_ready && !bus_b.abort && !reset) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_record_unexpected: got vector 0x%0h expected none", bus_b.rec_vector);
      end else begin
        e = q_b.pop_front();
        chk("b_record_vector", 32'(bus_b.rec_vector), 32'(e.v));
        chk("b_record_response", 32'(bus_b.rec_response), 32'(e.r));
      end
    end
  end

  task automatic cycle();
    @(posedge CK);
    #1;
  endtask

  task automatic pulse_start_a();
    bus_a.start = 1'b1;
    cycle();
    bus_a.start = 1'b0;
  endtask

  task automatic wait_rec_a(input int vec, input string name);
    int n = 0;
    while (!(bus_a.rec_valid && int'(bus_a.rec_vector) == vec) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) fail_now(name);
  endtask

  task automatic check_all_zero_a(input string tag);
    chk({tag, "_stim"}, 32'(bus_a.stim), 0);
    chk({tag, "_rec_valid"}, 32'(bus_a.rec_valid), 0);
    chk({tag, "_rec_vector"}, 32'(bus_a.rec_vector), 0);
    chk({tag, "_rec_response"}, 32'(bus_a.rec_response), 0);
    chk({tag, "_busy"}, 32'(bus_a.busy), 0);
    chk({tag, "_done"}, 32'(bus_a.done), 0);
    chk({tag, "_rec_count"}, 32'(bus_a.rec_count), 0);
  endtask

  initial begin
    int n;
    bus_a.start = 0; bus_a.abort = 0; bus_a.rec_ready = 1;
    bus_b.start = 0; bus_b.abort = 0; bus_b.rec_ready = 1;
    reset = 1'b1;
    repeat (3) @(posedge CK);
    #1 reset = 1'b0;
    check_all_zero_a("reset");
    chk_en = 1'b1;

    // Full sweep with ready high: done exactly NV*(S+1) cycles after t+1.
    repeat (6) cycle();
    pulse_start_a();
    n = 0;
    while (!bus_a.done && n < 2000) begin cycle(); n++; end
    chk("sweep_done_latency", 32'(n), 32'(NV * (S + 1)));
    chk("sweep_rec_count", 32'(bus_a.rec_count), 32'(NV));
    chk("sweep_records_left", 32'(q_a.size()), 0);
    cycle();
    chk("sweep_done_width", 32'(bus_a.done), 0);
    chk("sweep_busy_after", 32'(bus_a.busy), 0);

    // Backpressure on vector 3 for five cycles.
    pulse_start_a();
    wait_rec_a(3, "bp_wait_vec3");
    bus_a.rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_valid_held", 32'(bus_a.rec_valid), 1);
      chk("bp_vector_held", 32'(bus_a.rec_vector), 3);
      chk("bp_stim_held", 32'(bus_a.stim), 3);
    end
    bus_a.rec_ready = 1'b1;
    cycle();
    chk("bp_next_stim", 32'(bus_a.stim), 4);
    chk("bp_next_not_valid", 32'(bus_a.rec_valid), 0);

    // Abort in EMIT of vector 40 with a simultaneous handshake.
    wait_rec_a(40, "abort_wait_vec40");
    bus_a.abort = 1'b1;
    cycle();
    bus_a.abort = 1'b0;
    chk("abort_rec_valid", 32'(bus_a.rec_valid), 0);
    chk("abort_busy", 32'(bus_a.busy), 0);
    chk("abort_done", 32'(bus_a.done), 0);
    chk("abort_rec_count", 32'(bus_a.rec_count), 40);
    cycle();
    chk("abort_no_late_done", 32'(bus_a.done), 0);

    // Reset during SETTLE of vector 17, then restart from vector 0.
    pulse_start_a();
    n = 0;
    while (!(bus_a.busy && bus_a.stim == N'(17) && !bus_a.rec_valid) && n < 3000) begin
      cycle(); n++;
    end
    if (n >= 3000) fail_now("rst_wait_vec17");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_all_zero_a("midreset");
    pulse_start_a();
    chk("restart_stim", 32'(bus_a.stim), 0);
    chk("restart_busy", 32'(bus_a.busy), 1);
    repeat (20) cycle();
    bus_a.abort = 1'b1;
    cycle();
    bus_a.abort = 1'b0;

    // start held high for a whole sweep; the done cycle restarts it.
    bus_a.start = 1'b1;
    n = 0;
    while (!bus_a.done && n < 3000) begin
      bus_a.rec_ready = ($urandom_range(0, 3) != 0);
      cycle(); n++;
    end
    if (n >= 3000) fail_now("held_start_wait_done");
    chk("held_start_count", 32'(bus_a.rec_count), 32'(NV));
    cycle();
    chk("done_cycle_start_busy", 32'(bus_a.busy), 1);
    chk("done_cycle_start_stim", 32'(bus_a.stim), 0);
    chk("done_cycle_start_count", 32'(bus_a.rec_count), 0);
    bus_a.start = 1'b0;
    bus_a.rec_ready = 1'b1;
    bus_a.abort = 1'b1;
    cycle();
    bus_a.abort = 1'b0;

    // Random traffic on A: starts, aborts, resets and ready stalls.
    for (int i = 0; i < 4000; i++) begin
      bus_a.start     = ($urandom_range(0, 19) == 0);
      bus_a.abort     = ($urandom_range(0, 399) == 0);
      bus_a.rec_ready = ($urandom_range(0, 3) != 0);
      reset           = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    bus_a.start = 0; bus_a.abort = 0; bus_a.rec_ready = 1; reset = 0;
    cycle();

    // Instance B: one-cycle-late response captured with SETTLE_CYCLES=1.
    for (int v = 0; v < NVB; v++)
      q_b.push_back('{v: NB'(v), r: (v == 0) ? fb(0) : fb(v - 1)});
    bus_b.start = 1'b1;
    cycle();
    bus_b.start = 1'b0;
    chk("b_start_busy", 32'(bus_b.busy), 1);
    n = 0;
    while (!bus_b.done && n < 500) begin cycle(); n++; end
    chk("b_done_latency", 32'(n), 32'(NVB * (SB + 1)));
    chk("b_rec_count", 32'(bus_b.rec_count), 32'(NVB));
    chk("b_records_left", 32'(q_b.size()), 0);

    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
